// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// instr_fetch_unit : PC generation, single-outstanding instruction fetch and a
//                    small prefetch FIFO feeding decode over valid/ready.
// Revision         : 1.0
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        instr_mem_req_o,
  output logic [31:0] instr_mem_addr_o,
  input  logic [31:0] instr_mem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stop_flag_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        halted_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   tag_q, tag_d;
  logic          inflight_q, inflight_d;
  logic          kill_q, kill_d;
  logic          stopped_q, stopped_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   instr_mem_q [FIFO_DEPTH];
  logic [31:0]   pc_mem_q    [FIFO_DEPTH];

  logic          fifo_valid;
  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occ_next;

  always_comb begin
    fifo_valid = (count_q != '0);
    pop        = fifo_valid & ready_i & ~redirect_i;
    push       = inflight_q & ~kill_q & ~redirect_i;
    // Occupancy after this edge if we issue now; the in-flight word already owns a slot.
    occ_next   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q}
               + {{CW{1'b0}}, 1'b1} - {{CW{1'b0}}, pop};
    issue      = reset & ~stopped_q & ~stop_flag_i & ~redirect_i & (occ_next <= DEPTH_W);
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tag_d      = tag_q;
    inflight_d = issue;
    kill_d     = redirect_i & inflight_q;
    stopped_d  = stopped_q | stop_flag_i;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ~32'h0000_0003;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        tag_d      = fetch_pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      stopped_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      stopped_q  <= stopped_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Payload storage needs no reset: entries are only visible when counted.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= instr_mem_rdata_i;
      pc_mem_q[wr_ptr_q]    <= tag_q;
    end
  end

  always_comb begin
    instr_mem_req_o  = issue;
    instr_mem_addr_o = issue ? fetch_pc_q : '0;
    valid_o          = fifo_valid;
    instr_o          = fifo_valid ? instr_mem_q[rd_ptr_q] : '0;
    pc_o             = fifo_valid ? pc_mem_q[rd_ptr_q] : '0;
    halted_o         = stopped_q & ~fifo_valid & ~inflight_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// Bench for instr_fetch_unit: directed vector table, hand-written corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_instr_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, valid, halted, redirect, stop, ready;
  logic [31:0] addr, rdata, rpc, instr, pc;
  logic        w_req, w_valid, w_halted, w_ready, w_redirect, w_stop;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_rpc;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .instr_mem_req_o(req), .instr_mem_addr_o(addr), .instr_mem_rdata_i(rdata),
    .redirect_i(redirect), .redirect_pc_i(rpc), .stop_flag_i(stop), .ready_i(ready),
    .valid_o(valid), .instr_o(instr), .pc_o(pc), .halted_o(halted)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) dut_w (
    .clk(clk), .reset(reset),
    .instr_mem_req_o(w_req), .instr_mem_addr_o(w_addr), .instr_mem_rdata_i(w_rdata),
    .redirect_i(w_redirect), .redirect_pc_i(w_rpc), .stop_flag_i(w_stop), .ready_i(w_ready),
    .valid_o(w_valid), .instr_o(w_instr), .pc_o(w_pc), .halted_o(w_halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Synchronous instruction memories, one-cycle read latency.
  always @(posedge clk) begin
    if (req)   rdata   <= memf(addr);
    if (w_req) w_rdata <= memf(w_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of fetched {instr, pc} plus one pending memory read.
  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ent_t        mq[$];
  bit          m_pend, m_stop;
  logic [31:0] m_pend_pc, m_pc;

  function automatic void model_init();
    mq.delete();
    m_pend    = 1'b0;
    m_stop    = 1'b0;
    m_pend_pc = '0;
    m_pc      = 32'h0000_0000;
  endfunction

  logic        s_valid, s_req, s_halted, s_wvalid;
  logic [31:0] s_pc, s_addr, s_instr, s_wpc, s_winstr;

  task automatic step(input logic rdy, input logic redir, input logic [31:0] tgt,
                      input logic stp);
    bit          e_valid, e_req, pop;
    int          occ;
    logic [31:0] e_pc, e_instr;
    ready = rdy; redirect = redir; rpc = tgt; stop = stp;
    @(negedge clk);
    s_valid = valid; s_req = req; s_halted = halted; s_pc = pc; s_addr = addr;
    s_instr = instr; s_wvalid = w_valid; s_wpc = w_pc; s_winstr = w_instr;
    e_valid = (mq.size() != 0);
    e_pc = '0; e_instr = '0;
    if (e_valid) begin e_pc = mq[0].pc; e_instr = mq[0].instr; end
    pop   = e_valid && rdy && !redir;
    occ   = mq.size() + int'(m_pend) + 1 - int'(pop);
    e_req = !m_stop && !stp && !redir && (occ <= DEPTH);
    chk("req", s_req, e_req);
    if (e_req) chk("addr", s_addr, m_pc);
    chk("valid", s_valid, e_valid);
    chk("pc", s_pc, e_pc);
    chk("instr", s_instr, e_instr);
    chk("halted", s_halted, m_stop && mq.size() == 0 && !m_pend);
    if (stp) m_stop = 1'b1;
    if (redir) begin
      mq.delete();
      m_pend = 1'b0;
      m_pc   = tgt & ~32'h3;
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_pend) mq.push_back({memf(m_pend_pc), m_pend_pc});
      m_pend = e_req;
      if (e_req) begin m_pend_pc = m_pc; m_pc = m_pc + 32'd4; end
    end
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; asserts reset asynchronously and checks outputs before any edge.
  task automatic do_reset();
    reset = 1'b0; ready = 1'b0; redirect = 1'b0; stop = 1'b0;
    #1;
    chk("rst_req", req, 0);
    chk("rst_valid", valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_w_valid", w_valid, 0);
    @(posedge clk); #1;
    chk("rst_addr", addr, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    model_init();
  endtask

  typedef struct packed {
    logic rdy; logic ev; logic [31:0] epc; logic ereq; logic [31:0] eaddr;
  } vec_t;
  vec_t        tbl [12];
  logic [31:0] wrap_pc [3];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd0};
    tbl[1]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd4};
    tbl[2]  = '{1'b1, 1'b1, 32'd0,  1'b1, 32'd8};
    for (int i = 3; i < 8; i++) tbl[i] = '{1'b0, 1'b1, 32'd4, 1'b0, 32'd0};
    tbl[8]  = '{1'b1, 1'b1, 32'd4,  1'b1, 32'd12};
    tbl[9]  = '{1'b1, 1'b1, 32'd8,  1'b1, 32'd16};
    tbl[10] = '{1'b1, 1'b1, 32'd12, 1'b1, 32'd20};
    tbl[11] = '{1'b1, 1'b1, 32'd16, 1'b1, 32'd24};
    wrap_pc[0] = 32'hFFFF_FFF8; wrap_pc[1] = 32'hFFFF_FFFC; wrap_pc[2] = 32'h0000_0000;

    reset = 1'b0; ready = 1'b0; redirect = 1'b0; stop = 1'b0; rpc = '0; rdata = '0;
    w_ready = 1'b1; w_redirect = 1'b0; w_stop = 1'b0; w_rpc = '0; w_rdata = '0;
    model_init();
    @(posedge clk); #1;
    do_reset();

    // Streaming, stall/backpressure and wrap-around at the top of the address space.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rdy, 1'b0, 32'h0, 1'b0);
      chk("tbl_valid", s_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk("tbl_pc", s_pc, tbl[i].epc);
        chk("tbl_instr", s_instr, memf(tbl[i].epc));
      end
      chk("tbl_req", s_req, tbl[i].ereq);
      if (tbl[i].ereq) chk("tbl_addr", s_addr, tbl[i].eaddr);
      if (i >= 2 && i <= 4) begin
        chk("wrap_valid", s_wvalid, 1);
        chk("wrap_pc", s_wpc, wrap_pc[i-2]);
        chk("wrap_instr", s_winstr, memf(wrap_pc[i-2]));
      end else if (i < 2) begin
        chk("wrap_novalid", s_wvalid, 0);
      end
    end

    // Reset with a buffered word and a read in flight; restart from RESET_PC.
    do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("rr_addr", s_addr, 32'h0);
    chk("rr_valid0", s_valid, 0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("rr_valid1", s_valid, 0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("rr_pc", s_pc, 32'h0);

    // Redirect with a read in flight: word dropped, target visible three cycles later.
    step(1'b1, 1'b1, 32'h0000_0103, 1'b0);
    chk("rd_noreq", s_req, 0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("rd_req", s_req, 1);
    chk("rd_addr", s_addr, 32'h0000_0100);
    chk("rd_valid_c1", s_valid, 0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("rd_valid_c2", s_valid, 0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("rd_valid_c3", s_valid, 1);
    chk("rd_pc_c3", s_pc, 32'h0000_0100);

    // Stop pulse at c4: fetch ceases, FIFO drains, halted is sticky even across redirects.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("stop_noreq", s_req, 0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("stop_halted", s_halted, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom_range(0, 1)), 1'b1, $urandom, 1'b0);
      chk("stop_redir_noreq", s_req, 0);
      chk("stop_redir_halted", s_halted, 1);
    end
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("stop_after_redir", s_req, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 0) do_reset();
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0), $urandom,
           1'($urandom_range(0, 99) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
